// File: rtl/uart_rx_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl_if
// Signal bundle between the UART RX frame controller and its neighbours: the
// rx_in synchroniser, the frame configuration, the edge/bit counter, the data
// sampler and the deserializer/output register.
//
// Modports:
//   master - the frame controller: consumes line, configuration, counter and
//            sampler values; drives counter/sampler/deserializer controls and
//            the frame status.
//   slave  - the surrounding datapath: the mirror image of master.
//
// Signals:
//   rx_in       synchronised serial line, idle high
//   par_en      parity bit present in frame
//   par_typ     0 = even parity, 1 = odd parity
//   prescale    oversampling ratio per bit (8, 16 or 32)
//   edge_cnt    edge counter value within the current bit
//   bit_cnt     bit counter: 0 = start, 1..DATA_WIDTH = data, then parity/stop
//   sampled_bit data sampler majority result
//   cnt_en      edge/bit counter enable
//   cnt_clr     synchronous clear of edge_cnt and bit_cnt
//   samp_en     data sampler enable
//   deser_en    one-cycle shift strobe for the deserializer
//   data_valid  one-cycle strobe: deserializer holds a good byte
//   par_err     parity error of the last frame
//   stp_err     stop error of the last frame
// -----------------------------------------------------------------------------
interface uart_rx_ctrl_if #(
    parameter int PRESC_W = 6
);
    logic               rx_in;
    logic               par_en;
    logic               par_typ;
    logic [PRESC_W-1:0] prescale;
    logic [PRESC_W-1:0] edge_cnt;
    logic [3:0]         bit_cnt;
    logic               sampled_bit;

    logic               cnt_en;
    logic               cnt_clr;
    logic               samp_en;
    logic               deser_en;
    logic               data_valid;
    logic               par_err;
    logic               stp_err;

    modport master (
        input  rx_in, par_en, par_typ, prescale, edge_cnt, bit_cnt, sampled_bit,
        output cnt_en, cnt_clr, samp_en, deser_en, data_valid, par_err, stp_err
    );

    modport slave (
        output rx_in, par_en, par_typ, prescale, edge_cnt, bit_cnt, sampled_bit,
        input  cnt_en, cnt_clr, samp_en, deser_en, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-side frame controller for the UART RX path. Walks a frame
// (start, DATA_WIDTH data bits LSB first, optional parity, stop), runs the
// edge/bit counter and the data sampler, strobes the deserializer once per
// data bit, and checks start glitch, parity and stop bit.
//
// Ports:
//   clk    oversampling clock
//   rst_n  asynchronous active-low reset
//   bus    uart_rx_ctrl_if.master (line, configuration, counter/sampler
//          inputs; counter/sampler/deserializer controls and frame status)
//
// Timing within a bit: CHK = (prescale>>1)+2 is where the sampler result is
// consumed, END = prescale-1 is the last edge of the bit.
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

    state_e             state_q, state_d;
    // Frame configuration captured on the start edge so that mid-frame changes
    // on the configuration inputs cannot corrupt the frame in flight.
    logic               par_en_lat_q, par_en_lat_d;
    logic               par_typ_lat_q, par_typ_lat_d;
    logic [PRESC_W-1:0] prescale_lat_q, prescale_lat_d;
    logic               acc_q, acc_d;           // running XOR of data bits
    logic               deser_en_q, deser_en_d;
    logic               data_valid_q, data_valid_d;
    logic               par_err_q, par_err_d;
    logic               stp_err_q, stp_err_d;

    logic [PRESC_W-1:0] chk_edge;
    logic [PRESC_W-1:0] end_edge;
    logic               at_chk;
    logic               at_end;

    assign chk_edge = (prescale_lat_q >> 1) + PRESC_W'(2);
    assign end_edge = prescale_lat_q - PRESC_W'(1);
    assign at_chk   = (bus.edge_cnt == chk_edge);
    assign at_end   = (bus.edge_cnt == end_edge);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; without this always_comb would infer latches.
        state_d        = state_q;
        par_en_lat_d   = par_en_lat_q;
        par_typ_lat_d  = par_typ_lat_q;
        prescale_lat_d = prescale_lat_q;
        acc_d          = acc_q;
        par_err_d      = par_err_q;
        stp_err_d      = stp_err_q;
        deser_en_d     = 1'b0;
        data_valid_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!bus.rx_in) begin
                    state_d        = S_START;
                    par_en_lat_d   = bus.par_en;
                    par_typ_lat_d  = bus.par_typ;
                    prescale_lat_d = bus.prescale;
                    acc_d          = 1'b0;
                    par_err_d      = 1'b0;
                    stp_err_d      = 1'b0;
                end
            end

            S_START: begin
                // A start bit that is high again at the check point was noise.
                if (at_chk && bus.sampled_bit) begin
                    state_d = S_IDLE;
                end else if (at_end) begin
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                // The strobe lands one cycle after CHK; the sampler result
                // stays valid until the end of the bit, so the shift still
                // sees this bit's value.
                if (at_chk) begin
                    deser_en_d = 1'b1;
                    acc_d      = acc_q ^ bus.sampled_bit;
                end
                if (at_end && (bus.bit_cnt == LAST_DATA_BIT)) begin
                    state_d = par_en_lat_q ? S_PARITY : S_STOP;
                end
            end

            S_PARITY: begin
                if (at_chk) begin
                    par_err_d = bus.sampled_bit ^ acc_q ^ par_typ_lat_q;
                end
                if (at_end) begin
                    state_d = S_STOP;
                end
            end

            S_STOP: begin
                // Leave at CHK rather than END so a start bit that follows the
                // stop bit directly is caught on the first IDLE cycle.
                if (at_chk) begin
                    stp_err_d    = ~bus.sampled_bit;
                    data_valid_d = bus.sampled_bit & ~par_err_q;
                    state_d      = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            par_en_lat_q   <= 1'b0;
            par_typ_lat_q  <= 1'b0;
            prescale_lat_q <= PRESC_W'(8);
            acc_q          <= 1'b0;
            deser_en_q     <= 1'b0;
            data_valid_q   <= 1'b0;
            par_err_q      <= 1'b0;
            stp_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            par_en_lat_q   <= par_en_lat_d;
            par_typ_lat_q  <= par_typ_lat_d;
            prescale_lat_q <= prescale_lat_d;
            acc_q          <= acc_d;
            deser_en_q     <= deser_en_d;
            data_valid_q   <= data_valid_d;
            par_err_q      <= par_err_d;
            stp_err_q      <= stp_err_d;
        end
    end

    // Counter and sampler controls decode directly from the state register.
    assign bus.cnt_clr    = (state_q == S_IDLE);
    assign bus.cnt_en     = (state_q != S_IDLE);
    assign bus.samp_en    = (state_q != S_IDLE);
    assign bus.deser_en   = deser_en_q;
    assign bus.data_valid = data_valid_q;
    assign bus.par_err    = par_err_q;
    assign bus.stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed bench for uart_rx_ctrl. Surrounds the controller with a behavioural
// edge/bit counter, an ideal sampler (sampled_bit follows the line) and a
// shift-register deserializer, then drives hand-built frames.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;
    localparam int PRESC_W = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    uart_rx_ctrl_if #(.PRESC_W(PRESC_W)) bus ();

    uart_rx_ctrl #(.DATA_WIDTH(8), .PRESC_W(PRESC_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Edge/bit counter peer.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.edge_cnt <= '0;
            bus.bit_cnt  <= '0;
        end else if (bus.cnt_clr) begin
            bus.edge_cnt <= '0;
            bus.bit_cnt  <= '0;
        end else if (bus.cnt_en) begin
            if (int'(bus.edge_cnt) == int'(bus.prescale) - 1) begin
                bus.edge_cnt <= '0;
                bus.bit_cnt  <= bus.bit_cnt + 4'd1;
            end else begin
                bus.edge_cnt <= bus.edge_cnt + 6'd1;
            end
        end
    end

    // Observation state, sampled on the falling edge.
    int         deser_cnt, deser_bad, dv_cnt, dv_bad, active_cycles;
    int         idle_run = 0, last_idle_run = 0;
    int         last_edge = 0, cur_chk = 6;
    logic       prev_en = 1'b0;
    logic       first_idle_stp = 1'b0, first_idle_par = 1'b0;
    logic [7:0] shreg = 8'h00;
    logic [7:0] byte_log [4];

    always @(negedge clk) begin
        if (bus.deser_en) begin
            deser_cnt++;
            shreg = {bus.sampled_bit, shreg[7:1]};
            if (last_edge != cur_chk) deser_bad++;
        end
        if (bus.data_valid) begin
            if (dv_cnt < 4) byte_log[dv_cnt] = shreg;
            dv_cnt++;
            if (last_edge != cur_chk || bus.cnt_clr !== 1'b1) dv_bad++;
        end
        if (bus.cnt_en) active_cycles++;
        if (bus.cnt_clr) begin
            if (prev_en) begin
                first_idle_stp = bus.stp_err;
                first_idle_par = bus.par_err;
                idle_run       = 0;
            end
            idle_run++;
        end else if (!prev_en) begin
            last_idle_run = idle_run;
        end
        prev_en   = bus.cnt_en;
        last_edge = int'(bus.edge_cnt);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {25'd0, bus.cnt_en, bus.cnt_clr, bus.samp_en, bus.deser_en,
                bus.data_valid, bus.par_err, bus.stp_err};
    endfunction

    task automatic clear_stats();
        deser_cnt     = 0;
        deser_bad     = 0;
        dv_cnt        = 0;
        dv_bad        = 0;
        active_cycles = 0;
    endtask

    task automatic drive_bit(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            bus.rx_in       = v;
            bus.sampled_bit = v;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input int p, input logic with_par,
                              input logic par_bit, input logic stop_bit);
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(data[i], p);
        if (with_par) drive_bit(par_bit, p);
        drive_bit(stop_bit, p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n           = 1'b0;
        bus.rx_in       = 1'b1;
        bus.sampled_bit = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.rx_in       = 1'b1;
        bus.sampled_bit = 1'b1;
        bus.par_en      = 1'b0;
        bus.par_typ     = 1'b0;
        bus.prescale    = 6'd8;
        clear_stats();

        // Reset values: only cnt_clr high.
        #2 rst_n = 1'b0;
        #1 check("reset_outputs", outs(), 32'h20);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        drive_bit(1'b1, 3);

        // Test 1: prescale 8, no parity, 0x55.
        bus.prescale = 6'd8; bus.par_en = 1'b0; cur_chk = 6;
        clear_stats();
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 4);
        check("t1_deser_count", deser_cnt, 8);
        check("t1_deser_at_chk", deser_bad, 0);
        check("t1_dv_count", dv_cnt, 1);
        check("t1_dv_after_stop_chk", dv_bad, 0);
        check("t1_byte", byte_log[0], 8'h55);
        check("t1_par_err", first_idle_par, 1'b0);
        check("t1_stp_err", first_idle_stp, 1'b0);

        // Test 2: prescale 16, even parity, 0xA3 (four ones).
        bus.prescale = 6'd16; bus.par_en = 1'b1; bus.par_typ = 1'b0; cur_chk = 10;
        clear_stats();
        send_frame(8'hA3, 16, 1'b1, 1'b0, 1'b1);
        drive_bit(1'b1, 4);
        check("t2a_dv_count", dv_cnt, 1);
        check("t2a_byte", byte_log[0], 8'hA3);
        check("t2a_par_err", first_idle_par, 1'b0);
        clear_stats();
        send_frame(8'hA3, 16, 1'b1, 1'b1, 1'b1);
        drive_bit(1'b1, 4);
        check("t2b_deser_count", deser_cnt, 8);
        check("t2b_dv_count", dv_cnt, 0);
        check("t2b_par_err_held", bus.par_err, 1'b1);
        check("t2b_stp_err", bus.stp_err, 1'b0);

        // Test 3: prescale 8, 3-cycle glitch; active for CHK+1 = 7 cycles.
        bus.prescale = 6'd8; bus.par_en = 1'b0; cur_chk = 6;
        clear_stats();
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 12);
        check("t3_active_cycles", active_cycles, 7);
        check("t3_deser_count", deser_cnt, 0);
        check("t3_dv_count", dv_cnt, 0);
        check("t3_cnt_clr", bus.cnt_clr, 1'b1);
        check("t3_par_err_cleared", bus.par_err, 1'b0);

        // Test 4: prescale 32, stop bit low, then break held low.
        bus.prescale = 6'd32; cur_chk = 18;
        clear_stats();
        send_frame(8'h3C, 32, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 8);
        check("t4_stp_err", first_idle_stp, 1'b1);
        check("t4_dv_count", dv_cnt, 0);
        check("t4_single_idle", last_idle_run, 1);
        check("t4_restarted", bus.cnt_en, 1'b1);
        check("t4_stp_cleared_on_restart", bus.stp_err, 1'b0);
        do_reset();
        drive_bit(1'b1, 3);

        // Test 5: back-to-back 0x0F, 0xF0 at prescale 8.
        bus.prescale = 6'd8; cur_chk = 6;
        clear_stats();
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1);
        send_frame(8'hF0, 8, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 4);
        check("t5_dv_count", dv_cnt, 2);
        check("t5_deser_count", deser_cnt, 16);
        check("t5_byte0", byte_log[0], 8'h0F);
        check("t5_byte1", byte_log[1], 8'hF0);
        check("t5_single_idle", last_idle_run, 1);
        check("t5_dv_timing", dv_bad, 0);

        // Test 6: reset during data bit 4 of 0x81, then a clean 0x81.
        clear_stats();
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b0, 4);
        check("t6_in_frame", bus.cnt_en, 1'b1);
        check("t6_bit4", bus.bit_cnt, 4'd4);
        #2 rst_n = 1'b0;
        bus.rx_in = 1'b1; bus.sampled_bit = 1'b1;
        #1 check("t6_async_reset_outputs", outs(), 32'h20);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        check("t6_no_partial_dv", dv_cnt, 0);
        drive_bit(1'b1, 3);
        clear_stats();
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 4);
        check("t6_deser_count", deser_cnt, 8);
        check("t6_dv_count", dv_cnt, 1);
        check("t6_byte", byte_log[0], 8'h81);
        check("t6_stp_err", bus.stp_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side frame controller for the UART RX path. It sequences the edge/bit counter and the data sampler, walks a frame (start, data, optional parity, stop), and issues shift strobes to the deserializer. It performs the start-glitch, parity and stop checks and flags a valid byte. It sits between the rx_in pin synchroniser and the deserializer/output register.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (LSB first)
PRESC_W, 6, width of prescale and edge_cnt

Ports:
clk  input  1  system clock (oversampling clock)
rst_n  input  1  asynchronous active-low reset
rx_in  input  1  synchronised serial line, idle high
par_en  input  1  parity bit present in frame
par_typ  input  1  0 = even parity, 1 = odd parity
prescale  input  PRESC_W  oversampling ratio per bit; legal values 8, 16, 32
edge_cnt  input  PRESC_W  edge counter value, 0..prescale-1 within the current bit
bit_cnt  input  4  bit counter: 0 = start bit, 1..DATA_WIDTH = data bits, then parity/stop
sampled_bit  input  1  data sampler majority result; valid from edge_cnt >= CHK
cnt_en  output  1  enable to the edge/bit counter
cnt_clr  output  1  synchronous clear of edge_cnt and bit_cnt
samp_en  output  1  data sampler enable
deser_en  output  1  one-cycle strobe: shift sampled_bit into the deserializer
data_valid  output  1  one-cycle strobe: deserializer holds a good byte
par_err  output  1  parity error of the last frame
stp_err  output  1  stop error of the last frame

Behaviour:
- Reset is rst_n: asynchronous, active-low. Clock is clk. Reset forces state IDLE.
- Reset output values: cnt_en=0, cnt_clr=1, samp_en=0, deser_en=0, data_valid=0, par_err=0, stp_err=0.
- CHK = (prescale>>1)+2 is the check point. END = prescale-1 is the last edge of a bit.
- States are IDLE, START, DATA, PARITY and STOP. Registered state; all outputs come from registers or from the state.
- cnt_clr = (state==IDLE). cnt_en = samp_en = (state!=IDLE).
- IDLE:
  - When rx_in==0, go to START.
  - On that same edge, latch par_en, par_typ and prescale into internal copies used for the whole frame. Changes to these inputs mid-frame are ignored.
  - On that same edge, clear par_err, stp_err and the parity accumulator.
- START:
  - At edge_cnt==CHK, if sampled_bit==1 this is a glitch: return to IDLE. No data_valid, no error flag.
  - Otherwise, at edge_cnt==END, go to DATA.
- DATA:
  - At edge_cnt==CHK, pulse deser_en for 1 cycle and set acc ^= sampled_bit.
  - At edge_cnt==END with bit_cnt==DATA_WIDTH, go to PARITY if the latched par_en=1, else to STOP.
- PARITY:
  - At edge_cnt==CHK, set par_err <= sampled_bit ^ acc ^ par_typ_latched.
  - At edge_cnt==END, go to STOP.
- STOP:
  - At edge_cnt==CHK, set stp_err <= ~sampled_bit and go to IDLE. The controller does not wait out the stop bit, so it can accept back-to-back frames.
  - data_valid is registered: it pulses high exactly 1 cycle after the STOP CHK cycle, only if sampled_bit==1 and the par_err of this frame==0.
- Error flags hold until the next IDLE->START transition.
- deser_en fires exactly DATA_WIDTH times per accepted frame. It never fires in START, PARITY or STOP.
- If rx_in is low in IDLE immediately after STOP (next start bit), the controller enters START on the first IDLE cycle. Counters are cleared in that IDLE cycle.
- A break (line held low) gives stp_err=1 and no data_valid, then the controller re-enters START from IDLE.
- rst_n asserted mid-frame: immediate return to IDLE with the reset output values. No partial data_valid.
- Illegal or unused state encodings recover to IDLE on the next clock.

Test Plan:
- prescale=8, par_en=0, frame 0x55 with stop=1:
  - deser_en pulses 8 times, at edge_cnt==6 of bits 1..8.
  - data_valid is 1 cycle high after STOP CHK.
  - par_err=0 and stp_err=0.
- prescale=16, par_en=1, par_typ=0, data 0xA3, parity bit 0: par_err=0 and data_valid pulses. Same frame with parity bit 1: par_err=1 and no data_valid.
- prescale=8, 3-cycle low glitch on rx_in: the controller returns to IDLE at START CHK, cnt_clr=1 the next cycle, and no deser_en or data_valid occurs.
- prescale=32, par_en=0, stop bit=0: stp_err=1, no data_valid. With rx_in held low afterward, the controller enters START again on the first IDLE cycle.
- Two back-to-back frames 0x0F then 0xF0 with a single stop bit each: two data_valid pulses, and 16 deser_en total.
- rst_n low during DATA bit 4: all outputs take their reset values asynchronously. A subsequent clean frame 0x81 yields exactly 8 deser_en and one data_valid.
